// File: rtl/theta_module.sv
// Keccak theta step over a 5x5 lane state, streamed one lane per cycle.
// Loads 25 lanes while accumulating column parities C[x], forms the mixing
// terms D[x] in one cycle, then emits each lane XORed with D[x] in order.
module theta_module #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,        // asynchronous, active low
  input  logic         start,
  input  logic [W-1:0] inLane,
  input  logic         inValid,
  output logic         inReady,
  output logic [W-1:0] outLane,
  output logic [4:0]   outLaneid,
  output logic         outValid,
  input  logic         outReady,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DMIX,
    S_EMIT,
    S_DONE
  } state_t;

  state_t       r_state;
  state_t       w_state_next;

  logic [4:0]   r_cnt;        // lane index 0..24
  logic [2:0]   r_mod5;       // lane index mod 5 (column x), tracked alongside r_cnt
  logic [W-1:0] r_c [5];      // column parities
  logic [W-1:0] r_d [5];      // theta mixing terms
  logic [W-1:0] w_d [5];
  logic [W-1:0] r_buf [25];   // lane store, written in LOAD, read in EMIT
  logic [W-1:0] r_out_lane;
  logic         r_out_valid;

  logic         w_in_hs;
  logic         w_out_hs;
  logic         w_last;
  logic [4:0]   w_cnt_inc;
  logic [2:0]   w_mod5_inc;

  assign w_in_hs    = (r_state == S_LOAD) && inValid;
  assign w_out_hs   = r_out_valid && outReady;
  assign w_last     = (r_cnt == 5'd24);
  assign w_cnt_inc  = r_cnt + 5'd1;
  assign w_mod5_inc = (r_mod5 == 3'd4) ? 3'd0 : r_mod5 + 3'd1;

  assign outLane   = r_out_lane;
  assign outLaneid = r_cnt;
  assign outValid  = r_out_valid;

  // D[x] = C[x-1] ^ rot1(C[x+1]), column indices taken mod 5
  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_dmix
      assign w_d[gi] = r_c[(gi + 4) % 5] ^ {r_c[(gi + 1) % 5][W-2:0], r_c[(gi + 1) % 5][W-1]};
    end
  endgenerate

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  // Next-state decode and state-derived status outputs
  always_comb begin
    w_state_next = r_state;
    inReady      = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_state_next = S_LOAD;
      end
      S_LOAD: begin
        inReady = 1'b1;
        if (inValid && w_last) w_state_next = S_DMIX;
      end
      S_DMIX: w_state_next = S_EMIT;
      S_EMIT: if (w_out_hs && w_last) w_state_next = S_DONE;
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Lane store; never reset, only read after a complete LOAD has refilled it
  always_ff @(posedge clk) begin
    if (w_in_hs) r_buf[r_cnt] <= inLane;
  end

  // Counters, parity accumulation, mixing terms and the registered output lane
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_mod5      <= '0;
      r_out_lane  <= '0;
      r_out_valid <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        r_c[i] <= '0;
        r_d[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt  <= '0;
            r_mod5 <= '0;
            for (int i = 0; i < 5; i++) r_c[i] <= '0;
          end
        end
        S_LOAD: begin
          if (inValid) begin
            r_c[r_mod5] <= r_c[r_mod5] ^ inLane;
            if (w_last) begin
              r_cnt  <= '0;
              r_mod5 <= '0;
            end else begin
              r_cnt  <= w_cnt_inc;
              r_mod5 <= w_mod5_inc;
            end
          end
        end
        S_DMIX: begin
          for (int i = 0; i < 5; i++) r_d[i] <= w_d[i];
        end
        S_EMIT: begin
          // first EMIT cycle primes lane 0; afterwards each handshake advances
          if (!r_out_valid) begin
            r_out_lane  <= r_buf[r_cnt] ^ r_d[r_mod5];
            r_out_valid <= 1'b1;
          end else if (outReady) begin
            if (w_last) begin
              r_out_valid <= 1'b0;
              r_cnt       <= '0;
              r_mod5      <= '0;
            end else begin
              r_cnt      <= w_cnt_inc;
              r_mod5     <= w_mod5_inc;
              r_out_lane <= r_buf[w_cnt_inc] ^ r_d[w_mod5_inc];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
